// File: rtl/id_ex_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : id_ex_pkg
//  Description : Shared widths, NOP encoding, FSM state encodings and the
//                decoded-packet type carried through the id/ex stage register.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_ex_pkg;

    localparam int INST_BUS     = 32;
    localparam int INST_ADDR_BUS = 32;
    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;

    localparam logic [INST_BUS-1:0]     ZERO_WORD     = '0;
    localparam logic [REG_ADDR_BUS-1:0] ZERO_REG      = '0;
    localparam logic                    WRITE_ENABLE  = 1'b1;
    localparam logic                    WRITE_DISABLE = 1'b0;

    // addi x0, x0, 0
    localparam logic [INST_BUS-1:0] INST_NOP = 32'h0000_0013;

    // Occupancy of the two-entry (main + skid) buffer
    typedef enum logic [1:0] {
        IDEX_EMPTY = 2'd0,
        IDEX_ONE   = 2'd1,
        IDEX_TWO   = 2'd2
    } idex_state_e;

    typedef struct packed {
        logic [INST_BUS-1:0]      inst;
        logic [INST_ADDR_BUS-1:0] instaddr;
        logic [REG_BUS-1:0]       op1;
        logic [REG_BUS-1:0]       op2;
        logic                     regs_wen;
        logic [REG_ADDR_BUS-1:0]  rd_addr;
    } idex_pkt_t;

endpackage
`default_nettype wire

// File: rtl/id_ex_pipe_entry.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : id_ex_pipe_entry
//  Description : One decoded-packet register with load enable and synchronous
//                clear. Clear wins over load.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe_entry
    import id_ex_pkg::*;
(
    input  logic      clk,
    input  logic      clr,
    input  logic      load,
    input  idex_pkt_t d,
    output idex_pkt_t q
);

    idex_pkt_t r_q;

    // Hold the packet until cleared or overwritten by a new load
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/id_ex.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : id_ex
//  Description : id -> ex pipeline register. Valid/ready handshake backed by a
//                main + skid entry so in_ready_o is a flop with no path from
//                out_ready_i. Flush drops everything; a saturating counter
//                records cycles where ex stalls a valid packet.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex
    import id_ex_pkg::*;
#(
    parameter logic [31:0] NOP_INST = INST_NOP,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      instaddr_i,
    input  logic [31:0]      op1_i,
    input  logic [31:0]      op2_i,
    input  logic             regs_wen_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      inst_o,
    output logic [31:0]      instaddr_o,
    output logic [31:0]      op1_o,
    output logic [31:0]      op2_o,
    output logic             regs_wen_o,
    output logic [4:0]       rd_addr_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    idex_state_e      r_state;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_stall_cnt;

    idex_pkt_t w_in_pkt;
    idex_pkt_t w_main_d;
    idex_pkt_t w_main_q;
    idex_pkt_t w_skid_q;
    logic      w_out_valid;
    logic      w_accept;
    logic      w_retire;
    logic      w_main_load;
    logic      w_skid_load;
    logic      w_clear;

    assign w_out_valid = (r_state != IDEX_EMPTY);
    assign w_accept    = in_valid_i & r_in_ready;
    assign w_retire    = w_out_valid & out_ready_i;
    assign w_clear     = rst | flush_i;

    assign w_in_pkt = '{inst:     inst_i,
                        instaddr: instaddr_i,
                        op1:      op1_i,
                        op2:      op2_i,
                        regs_wen: regs_wen_i,
                        rd_addr:  rd_addr_i};

    // Entry load enables: main takes the input on a fill or a pass-through,
    // or takes the skid copy when the older packet retires out of TWO
    always_comb begin
        w_main_load = 1'b0;
        w_skid_load = 1'b0;
        w_main_d    = w_in_pkt;
        case (r_state)
            IDEX_EMPTY: begin
                w_main_load = w_accept;
            end
            IDEX_ONE: begin
                w_main_load = w_accept & w_retire;
                w_skid_load = w_accept & ~w_retire;
            end
            IDEX_TWO: begin
                w_main_load = w_retire;
                w_main_d    = w_skid_q;
            end
            default: begin
                w_main_load = 1'b0;
            end
        endcase
    end

    id_ex_pipe_entry u_main (
        .clk  (clk),
        .clr  (w_clear),
        .load (w_main_load),
        .d    (w_main_d),
        .q    (w_main_q)
    );

    id_ex_pipe_entry u_skid (
        .clk  (clk),
        .clr  (w_clear),
        .load (w_skid_load),
        .d    (w_in_pkt),
        .q    (w_skid_q)
    );

    // Occupancy FSM; in_ready is decoded from the next state and registered
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_state    <= IDEX_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                IDEX_EMPTY: begin
                    if (w_accept) begin
                        r_state <= IDEX_ONE;
                    end
                end
                IDEX_ONE: begin
                    if (w_accept && !w_retire) begin
                        r_state    <= IDEX_TWO;
                        r_in_ready <= 1'b0;
                    end else if (!w_accept && w_retire) begin
                        r_state <= IDEX_EMPTY;
                    end
                end
                IDEX_TWO: begin
                    if (w_retire) begin
                        r_state    <= IDEX_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDEX_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of cycles where ex holds off a valid packet
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready_i && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Empty stage presents a NOP with no register write
    assign in_ready_o  = r_in_ready;
    assign out_valid_o = w_out_valid;
    assign inst_o      = w_out_valid ? w_main_q.inst     : NOP_INST;
    assign instaddr_o  = w_out_valid ? w_main_q.instaddr : ZERO_WORD;
    assign op1_o       = w_out_valid ? w_main_q.op1      : ZERO_WORD;
    assign op2_o       = w_out_valid ? w_main_q.op2      : ZERO_WORD;
    assign regs_wen_o  = w_out_valid ? w_main_q.regs_wen : WRITE_DISABLE;
    assign rd_addr_o   = w_out_valid ? w_main_q.rd_addr  : ZERO_REG;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex
//  Description : Directed self-checking bench for id_ex with a queue-based
//                scoreboard of the buffered packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex;
    import id_ex_pkg::*;

    localparam int          CNT_W = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      inst_i;
    logic [31:0]      instaddr_i;
    logic [31:0]      op1_i;
    logic [31:0]      op2_i;
    logic             regs_wen_i;
    logic [4:0]       rd_addr_i;
    logic             flush_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      inst_o;
    logic [31:0]      instaddr_o;
    logic [31:0]      op1_o;
    logic [31:0]      op2_o;
    logic             regs_wen_o;
    logic [4:0]       rd_addr_o;
    logic [CNT_W-1:0] stall_cnt_o;

    always #5 clk = ~clk;

    id_ex #(.NOP_INST(NOP), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .inst_i      (inst_i),
        .instaddr_i  (instaddr_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .regs_wen_i  (regs_wen_i),
        .rd_addr_i   (rd_addr_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .inst_o      (inst_o),
        .instaddr_o  (instaddr_o),
        .op1_o       (op1_o),
        .op2_o       (op2_o),
        .regs_wen_o  (regs_wen_o),
        .rd_addr_o   (rd_addr_o),
        .stall_cnt_o (stall_cnt_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Packet k: addi x(k+1), x0, 5*(k+1) plus distinct side fields
    function automatic idex_pkt_t mk(input int k);
        idex_pkt_t p;
        p.inst     = {12'(5 * (k + 1)), 5'd0, 3'b000, 5'(k + 1), 7'h13};
        p.instaddr = 32'h0000_1000 + 32'(4 * k);
        p.op1      = 32'(k) * 32'h0000_0111;
        p.op2      = ~32'(k);
        p.regs_wen = ((k % 3) != 2);
        p.rd_addr  = 5'(k + 1);
        return p;
    endfunction

    task automatic offer(input int k);
        idex_pkt_t p;
        p          = mk(k);
        in_valid_i = 1'b1;
        inst_i     = p.inst;
        instaddr_i = p.instaddr;
        op1_i      = p.op1;
        op2_i      = p.op2;
        regs_wen_i = p.regs_wen;
        rd_addr_i  = p.rd_addr;
    endtask

    task automatic idle();
        in_valid_i = 1'b0;
        inst_i     = 'x;
        instaddr_i = 'x;
        op1_i      = 'x;
        op2_i      = 'x;
        regs_wen_i = 1'bx;
        rd_addr_i  = 'x;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: queue of packets held in the stage, head = main entry
    idex_pkt_t        sb[$];
    logic [CNT_W-1:0] m_stall = '0;
    int               n_ret   = 0;
    bit               mon_en  = 1'b0;

    always @(posedge clk) begin
        idex_pkt_t inp;
        bit        acc;
        bit        ret;
        inp = '{inst: inst_i, instaddr: instaddr_i, op1: op1_i, op2: op2_i,
                regs_wen: regs_wen_i, rd_addr: rd_addr_i};
        if (rst) begin
            sb.delete();
            m_stall = '0;
        end else begin
            if (sb.size() != 0 && !out_ready_i && m_stall != {CNT_W{1'b1}})
                m_stall = m_stall + 1'b1;
            if (flush_i) begin
                sb.delete();
            end else begin
                acc = in_valid_i && (sb.size() != 2);
                ret = (sb.size() != 0) && out_ready_i;
                if (ret) begin
                    void'(sb.pop_front());
                    n_ret++;
                end
                if (acc) sb.push_back(inp);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", out_valid_o, sb.size() != 0);
            chk("in_ready", in_ready_o, sb.size() != 2);
            chk("stall_cnt", stall_cnt_o, m_stall);
            if (sb.size() != 0)
                chk("head_pkt", {inst_o, instaddr_o, op1_o, op2_o, regs_wen_o, rd_addr_o}, sb[0]);
            else
                chk("empty_pkt", {inst_o, instaddr_o, op1_o, op2_o, regs_wen_o, rd_addr_o},
                    {NOP, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0});
        end
    end

    initial begin
        rst         = 1'b1;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        idle();
        cyc();
        mon_en = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();

        // Reset then idle
        chk("rst_valid", out_valid_o, 1'b0);
        chk("rst_inst", inst_o, 32'h13);
        chk("rst_wen", regs_wen_o, 1'b0);
        chk("rst_ready", in_ready_o, 1'b1);
        chk("rst_stall", stall_cnt_o, 4'h0);

        // Streaming, one packet per cycle, one-cycle latency
        for (int k = 0; k < 4; k++) begin
            offer(k);
            cyc();
            chk("stream_inst", inst_o, mk(k).inst);
            chk("stream_ready", in_ready_o, 1'b1);
        end
        idle();
        cyc();
        cyc();

        // Stall: A in main, B to skid, C held at id
        out_ready_i = 1'b0;
        offer(4);
        cyc();
        chk("stall_a", inst_o, mk(4).inst);
        offer(5);
        cyc();
        chk("stall_ready_lo", in_ready_o, 1'b0);
        chk("stall_a_hold", inst_o, mk(4).inst);
        offer(6);
        cyc();
        cyc();
        chk("stall_cnt3", stall_cnt_o, 4'd3);
        out_ready_i = 1'b1;
        cyc();
        chk("release_b", inst_o, mk(5).inst);
        chk("release_ready", in_ready_o, 1'b1);
        cyc();
        chk("release_c", inst_o, mk(6).inst);
        idle();
        cyc();
        cyc();

        // Flush in TWO with a packet offered
        out_ready_i = 1'b0;
        offer(7);
        cyc();
        offer(8);
        cyc();
        chk("two_ready", in_ready_o, 1'b0);
        offer(9);
        flush_i = 1'b1;
        cyc();
        chk("flush_valid", out_valid_o, 1'b0);
        chk("flush_wen", regs_wen_o, 1'b0);
        chk("flush_ready", in_ready_o, 1'b1);
        chk("flush_inst", inst_o, NOP);
        chk("flush_keep_cnt", stall_cnt_o, 4'd5);
        flush_i = 1'b0;
        idle();
        cyc();

        // Flush in ONE with an acceptable packet offered
        offer(10);
        cyc();
        offer(11);
        flush_i = 1'b1;
        cyc();
        chk("flush1_valid", out_valid_o, 1'b0);
        flush_i = 1'b0;
        idle();
        cyc();

        // Saturation
        offer(12);
        cyc();
        idle();
        repeat (20) cyc();
        chk("sat", stall_cnt_o, 4'hF);
        cyc();
        chk("sat_hold", stall_cnt_o, 4'hF);

        // Synchronous reset while in TWO
        offer(13);
        cyc();
        chk("pre_rst_ready", in_ready_o, 1'b0);
        idle();
        rst = 1'b1;
        #2;
        chk("rst_mid_valid", out_valid_o, 1'b1);
        chk("rst_mid_stall", stall_cnt_o, 4'hF);
        cyc();
        chk("rst2_valid", out_valid_o, 1'b0);
        chk("rst2_ready", in_ready_o, 1'b1);
        chk("rst2_stall", stall_cnt_o, 4'h0);
        chk("rst2_inst", inst_o, NOP);
        rst = 1'b0;

        // Post-reset traffic
        out_ready_i = 1'b1;
        offer(14);
        cyc();
        chk("post_rst", inst_o, mk(14).inst);
        idle();
        cyc();
        cyc();

        chk("n_retired", n_ret, 8);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
